// File: rtl/sat_pkg.sv
// sat_pkg: shared clause/literal geometry, drain FSM states and literal helpers.
package sat_pkg;
   localparam int NSAT                     = 3;
   localparam int LITERAL_ADDRESS_WIDTH    = 11;
   localparam int MAX_CLAUSES_PER_VARIABLE = 20;
   localparam int NSAT_BITS                = 2;
   localparam int CNT_BITS                 = 5;
   localparam int LIT_W                    = LITERAL_ADDRESS_WIDTH + 1;
   localparam int CLAUSE_W                 = NSAT * LIT_W;
   localparam logic [LITERAL_ADDRESS_WIDTH-1:0] NULL_ADDR = '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} drain_state_e;

   // Address 0 is reserved, so a literal pointing there marks an unused slot.
   function automatic logic lit_is_null(input logic [LIT_W-1:0] lit);
      return lit[LITERAL_ADDRESS_WIDTH-1:0] == NULL_ADDR;
   endfunction
endpackage

// File: rtl/tb_drain_next_slot.sv
// tb_drain_next_slot: lowest non-empty slot at or above from_i, plus a found flag.
module tb_drain_next_slot
   import sat_pkg::*;
(
   input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] used_i,
   input  logic [CNT_BITS-1:0]                 from_i,
   output logic [CNT_BITS-1:0]                 slot_o,
   output logic                                found_o
);
   always_comb begin
      slot_o  = '0;
      found_o = 1'b0;
      for (int k = MAX_CLAUSES_PER_VARIABLE - 1; k >= 0; k--)
         if (used_i[k] && CNT_BITS'(k) >= from_i) begin
            slot_o  = CNT_BITS'(k);
            found_o = 1'b1;
         end
   end
endmodule

// File: rtl/temporal_buffer_drain.sv
// temporal_buffer_drain: reads one buffered flip, snapshots its clause slots and streams them out.
// TB_DRAIN_SKIP_EMPTY_EN: skip slots whose first literal is null instead of emitting every slot.
module temporal_buffer_drain
   import sat_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             start_i,
   input  logic [NSAT_BITS-1:0]                             sel_index_i,
   output logic [NSAT_BITS-1:0]                             read_index_o,
   input  logic [MAX_CLAUSES_PER_VARIABLE*CLAUSE_W-1:0]     clause_multi_i,
   output logic [CLAUSE_W-1:0]                              clause_o,
   output logic [CNT_BITS-1:0]                              slot_o,
   output logic                                             clause_valid_o,
   input  logic                                             clause_ready_i,
   output logic                                             busy_o,
   output logic                                             done_o,
   output logic [CNT_BITS-1:0]                              count_o
);
   drain_state_e                                     state_q;
   logic [1:0]                                       lat_q;
   logic [MAX_CLAUSES_PER_VARIABLE-1:0][CLAUSE_W-1:0] in_w, snap_q, src_w;
   logic [CNT_BITS-1:0]                              nx_slot;
   logic                                             nx_found, xfer, adv;

   assign in_w  = clause_multi_i;
   assign src_w = state_q == S_WAIT ? in_w : snap_q;
   assign xfer  = clause_valid_o & clause_ready_i;
   // Slot advance happens at capture (picking the first slot) and on every transfer.
   assign adv   = (state_q == S_WAIT && lat_q == '0) || (state_q == S_EMIT && xfer);

`ifdef TB_DRAIN_SKIP_EMPTY_EN
   logic [MAX_CLAUSES_PER_VARIABLE-1:0] used_w;
   logic [CNT_BITS-1:0]                 from_w;
   always_comb
      for (int k = 0; k < MAX_CLAUSES_PER_VARIABLE; k++)
         used_w[k] = !lit_is_null(src_w[k][LIT_W-1:0]);
   assign from_w = state_q == S_WAIT ? '0 : slot_o + 1'b1;
   tb_drain_next_slot u_next (
      .used_i (used_w),
      .from_i (from_w),
      .slot_o (nx_slot),
      .found_o(nx_found)
   );
`else
   assign nx_slot  = state_q == S_WAIT ? '0 : slot_o + 1'b1;
   assign nx_found = state_q == S_WAIT || slot_o != CNT_BITS'(MAX_CLAUSES_PER_VARIABLE - 1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         lat_q          <= '0;
         snap_q         <= '0;
         read_index_o   <= '0;
         clause_o       <= '0;
         slot_o         <= '0;
         clause_valid_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         count_o        <= '0;
      end else begin
         case (state_q)
            S_IDLE:
               if (start_i) begin
                  read_index_o <= sel_index_i;
                  count_o      <= '0;
                  busy_o       <= 1'b1;
                  lat_q        <= 2'(READ_LATENCY);
                  state_q      <= S_WAIT;
               end
            S_WAIT:
               if (lat_q != '0) lat_q <= lat_q - 1'b1;
               else snap_q <= in_w;
            S_EMIT:
               if (xfer) count_o <= count_o + 1'b1;
            S_DONE: begin
               done_o  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         if (adv) begin
            if (nx_found) begin
               slot_o         <= nx_slot;
               clause_o       <= src_w[nx_slot];
               clause_valid_o <= 1'b1;
               state_q        <= S_EMIT;
            end else begin
               clause_valid_o <= 1'b0;
               busy_o         <= 1'b0;
               done_o         <= 1'b1;
               state_q        <= S_DONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_temporal_buffer_drain.sv
// tb_temporal_buffer_drain: directed drains checked through an expected-transfer scoreboard.
module tb_temporal_buffer_drain;
   import sat_pkg::*;
`ifdef TB_DRAIN_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam int SBW = CNT_BITS + CLAUSE_W;

   logic clk = 1'b0;
   logic reset, start_i, clause_ready_i;
   logic [NSAT_BITS-1:0] sel_index_i, read_index_o;
   logic [MAX_CLAUSES_PER_VARIABLE-1:0][CLAUSE_W-1:0] data;
   logic [CLAUSE_W-1:0] clause_o;
   logic [CNT_BITS-1:0] slot_o, count_o;
   logic clause_valid_o, busy_o, done_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [SBW-1:0] sb[$];
   int cnt_q[$];
   logic stall = 1'b0;
   logic [SBW-1:0] held;
   logic [3:0] rp = 4'b1001;

   temporal_buffer_drain #(.READ_LATENCY(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .sel_index_i   (sel_index_i),
      .read_index_o  (read_index_o),
      .clause_multi_i(data),
      .clause_o      (clause_o),
      .slot_o        (slot_o),
      .clause_valid_o(clause_valid_o),
      .clause_ready_i(clause_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (stall) begin
         chk("stall_valid", 64'(clause_valid_o), 64'd1);
         chk("stall_data", 64'({slot_o, clause_o}), 64'(held));
      end
      stall = clause_valid_o && !clause_ready_i;
      held  = {slot_o, clause_o};
      if (clause_valid_o && clause_ready_i) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_xfer: got slot %0d clause %0h expected none", slot_o, clause_o);
         end else chk("xfer", 64'({slot_o, clause_o}), 64'(sb.pop_front()));
      end
      if (done_o) begin
         chk("drain_left", 64'(sb.size()), 64'd0);
         if (cnt_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done expected none");
         end else chk("count", 64'(count_o), 64'(cnt_q.pop_front()));
      end
   end

   // mode 0: every slot used, 1: only slots 3, 7, 19 used, 2: all slots empty
   task automatic fill(input int seed, input int mode);
      for (int k = 0; k < MAX_CLAUSES_PER_VARIABLE; k++) begin
         data[k] = {1'b1, 11'(k * 37 + seed), 1'b0, 11'(k * 5 + seed * 3 + 9),
                    1'(k), 11'((k * 13 + seed) % 2047 + 1)};
         if (mode == 2 || (mode == 1 && k != 3 && k != 7 && k != 19))
            data[k][LITERAL_ADDRESS_WIDTH-1:0] = '0;
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_read_index"}, 64'(read_index_o), 64'd0);
      chk({nm, "_clause"}, 64'(clause_o), 64'd0);
      chk({nm, "_slot"}, 64'(slot_o), 64'd0);
      chk({nm, "_valid"}, 64'(clause_valid_o), 64'd0);
      chk({nm, "_busy"}, 64'(busy_o), 64'd0);
      chk({nm, "_done"}, 64'(done_o), 64'd0);
      chk({nm, "_count"}, 64'(count_o), 64'd0);
   endtask

   task automatic drain(input logic [1:0] sel, input bit bp, input bit busy_start,
                        input bit done_start, input int rst_slot);
      int n = 0;
      bit fin = 1'b0;
      for (int k = 0; k < MAX_CLAUSES_PER_VARIABLE; k++)
         if (!(SKIP && data[k][LITERAL_ADDRESS_WIDTH-1:0] == '0)) begin
            sb.push_back({CNT_BITS'(k), data[k]});
            n++;
         end
      cnt_q.push_back(n);
      @(posedge clk); #1;
      start_i = 1'b1;
      sel_index_i = sel;
      @(posedge clk); #1;
      start_i = 1'b0;
      sel_index_i = ~sel;
      chk("read_index", 64'(read_index_o), 64'(sel));
      chk("busy", 64'(busy_o), 64'd1);
      for (int c = 0; c < 200 && !fin; c++) begin
         clause_ready_i = bp ? rp[c % 4] : 1'b1;
         start_i = busy_start && c == 3;
         @(posedge clk); #1;
         if (rst_slot >= 0 && clause_valid_o && slot_o == CNT_BITS'(rst_slot)) begin
            #1 reset = 1'b1;
            #1 chk_zero("async_reset");
            reset = 1'b0;
            sb.delete();
            cnt_q.delete();
            fin = 1'b1;
         end else if (done_o) begin
            chk("done_valid", 64'(clause_valid_o), 64'd0);
            chk("done_busy", 64'(busy_o), 64'd0);
            start_i = done_start;
            sel_index_i = sel + 2'd1;
            @(posedge clk); #1;
            start_i = 1'b0;
            chk("after_done_busy", 64'(busy_o), 64'd0);
            chk("after_done_pulse", 64'(done_o), 64'd0);
            chk("read_index_hold", 64'(read_index_o), 64'(sel));
            fin = 1'b1;
         end else if (clause_valid_o)
            for (int k = 0; k < MAX_CLAUSES_PER_VARIABLE; k++)
               data[k] = CLAUSE_W'({$urandom(), $urandom()});
      end
      start_i = 1'b0;
      if (!fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got no done expected done within 200 cycles");
      end
   endtask

   initial begin
      reset = 1'b1;
      start_i = 1'b0;
      clause_ready_i = 1'b0;
      sel_index_i = '0;
      fill(0, 0);
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      reset = 1'b0;
      fill(1, 0); drain(2'd2, 1'b0, 1'b0, 1'b0, -1);
      fill(2, 0); drain(2'd1, 1'b1, 1'b0, 1'b0, -1);
      fill(3, 1); drain(2'd3, 1'b0, 1'b0, 1'b0, -1);
      fill(4, 2); drain(2'd0, 1'b1, 1'b0, 1'b0, -1);
      fill(5, 0); drain(2'd2, 1'b0, 1'b1, 1'b1, -1);
      fill(6, 0); drain(2'd2, 1'b0, 1'b0, 1'b0, 5);
      fill(7, 0); drain(2'd1, 1'b1, 1'b0, 1'b0, -1);
      repeat (3) @(posedge clk);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      chk("final_cnt_empty", 64'(cnt_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/temporal_buffer_drain.md
Name: temporal_buffer_drain

Overview:
- Read-side controller for the temporal buffer array.
- On a start request carrying the heuristic-selected flip index, it does the following:
  - drives the buffer's read index;
  - waits the buffer read latency;
  - snapshots all MAX_CLAUSES_PER_VARIABLE candidate clauses;
  - streams them one per handshake to the clause-update / broken-clause logic downstream.
- Sits between the temporal buffer wrapper output and the clause update path.

Parameters:
- NSAT, 3, literals per clause.
- LITERAL_ADDRESS_WIDTH, 11, variable address bits; each literal is LITERAL_ADDRESS_WIDTH+1 bits, {polarity MSB, address}.
- MAX_CLAUSES_PER_VARIABLE, 20, clause slots per buffered flip.
- NSAT_BITS, 2, width of flip index.
- READ_LATENCY, 1, cycles from read_index_o change to valid clause_multi_i (legal 0..3).
- CNT_BITS, 5, slot counter width; must satisfy 2^CNT_BITS > MAX_CLAUSES_PER_VARIABLE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  single-cycle request to drain one flip
- sel_index_i  in  NSAT_BITS  selected flip, sampled with start_i
- read_index_o  out  NSAT_BITS  to temporal buffer wrapper read index
- clause_multi_i  in  NSAT*MAX_CLAUSES_PER_VARIABLE*(LITERAL_ADDRESS_WIDTH+1)  buffered clauses; slot k at bit k*NSAT*(LITERAL_ADDRESS_WIDTH+1)
- clause_o  out  NSAT*(LITERAL_ADDRESS_WIDTH+1)  current clause
- slot_o  out  CNT_BITS  slot number of clause_o
- clause_valid_o  out  1  clause_o valid
- clause_ready_i  in  1  downstream accepts
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse after last transfer
- count_o  out  CNT_BITS  clauses transferred in last drain; held until next start

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; snapshot register and counters cleared.
- States: IDLE -> WAIT -> EMIT -> DONE -> IDLE.
- IDLE:
  - on start_i, register sel_index_i into read_index_o, clear count_o, set busy_o, and load the latency counter with READ_LATENCY.
  - start_i while busy is ignored; no queueing.
- WAIT:
  - decrement the latency counter; when it reaches 0, capture clause_multi_i into the snapshot and enter EMIT.
  - READ_LATENCY=0: capture happens in the cycle after start, so clause_valid_o can rise no earlier than start+2.
- EMIT:
  - clause_o/slot_o present the current slot from the snapshot; clause_valid_o is high.
  - Transfer = clause_valid_o & clause_ready_i; on a transfer, count_o++ and advance to the next slot.
  - clause_o, slot_o and clause_valid_o stay stable while ready is low.
  - After the transfer of the last slot, go to DONE.
- Empty slot: literal 0 of the slot has address field == 0. Address 0 is reserved as null.
- DONE: done_o=1 for exactly one cycle, busy_o drops, clause_valid_o=0, return to IDLE. A start_i in the DONE cycle is ignored.
- read_index_o holds its value after the drain until the next accepted start.
- Snapshot isolation: changes to clause_multi_i after capture do not affect emitted data.
- All outputs are registered; no combinational path from clause_ready_i to clause_valid_o.

Optional Feature:
- Macro: TB_DRAIN_SKIP_EMPTY_EN.
- Defined:
  - empty slots are never presented; a priority encoder selects the next non-empty slot at or above the pointer, in the same cycle.
  - If the capture finds no non-empty slot, go straight WAIT -> DONE with count_o=0 and no valid.
  - slot_o reports the true slot number.
- Undefined: all MAX_CLAUSES_PER_VARIABLE slots are emitted in order, empty ones included, and count_o=MAX_CLAUSES_PER_VARIABLE.

Decomposition:
- Shared package (sat_pkg):
  - literal width constant LIT_W = LITERAL_ADDRESS_WIDTH+1;
  - clause width CLAUSE_W = NSAT*LIT_W;
  - NULL_ADDR = 0;
  - drain state enum;
  - helper function lit_is_null.
- One sub-module: tb_drain_next_slot, a priority encoder returning the next non-empty slot index plus a found flag. It is instantiated only under TB_DRAIN_SKIP_EMPTY_EN.

Test Plan:
- Basic drain: start_i with sel_index_i=2, READ_LATENCY=1, ready tied 1, all 20 slots non-empty -> read_index_o=2 one cycle after start; 20 consecutive transfers, slot_o 0..19; done_o pulses; count_o=20.
- Backpressure: ready toggles 1,0,0,1 pattern -> clause_o and slot_o stable while ready=0; no slot dropped or duplicated; count_o=20.
- Skip empty (macro on): only slots 3, 7 and 19 non-empty -> exactly 3 transfers with slot_o=3,7,19; count_o=3. With no slots non-empty -> done_o with no valid and count_o=0.
- Snapshot isolation: change clause_multi_i every cycle after capture -> emitted data equals the value sampled READ_LATENCY cycles after start.
- Start while busy, plus start in the DONE cycle -> both ignored; read_index_o unchanged.
- Async reset asserted mid-EMIT at slot 5 -> all outputs 0 immediately; a new start after release drains from slot 0.
